// File: rtl/frame_mon_pkg.sv
// Shared types and constants for the DVP frame monitor.
// The FPS window logic is built only when FRAME_MON_FPS_EN is defined.
package frame_mon_pkg;

  typedef enum logic [1:0] {
    LED_OFF    = 2'd0,
    LED_SEARCH = 2'd1,
    LED_LOCKED = 2'd2
  } led_state_e;

  localparam int FPS_W = 8;
  localparam logic [FPS_W-1:0] FPS_MAX = 8'd255;

  function automatic logic [FPS_W-1:0] sat_inc(input logic [FPS_W-1:0] v);
    return (v == FPS_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_mon_chan.sv
// One vsync channel: synchroniser, edge detect, frame counter, watchdog, LED FSM.
// The per-channel FPS edge counter exists only when FRAME_MON_FPS_EN is defined.
module frame_mon_chan
  import frame_mon_pkg::*;
#(
  parameter int FRAMES_PER_TOGGLE = 60,
  parameter int LOST_TIMEOUT      = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready,
  input  logic             vsync,
  input  logic             blink,
`ifdef FRAME_MON_FPS_EN
  input  logic             win_last,
  output logic [FPS_W-1:0] fps,
`endif
  output logic             frame_tick,
  output logic             heartbeat,
  output logic             lost,
  output logic             led
);

  localparam int FCW = $clog2(FRAMES_PER_TOGGLE);
  localparam int WDW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_TOGGLE - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(LOST_TIMEOUT);
  localparam logic [WDW-1:0] WD_PRE  = WDW'(LOST_TIMEOUT - 1);

  logic           sync0, sync1, prev;
  logic           edge_det;
  logic [FCW-1:0] frame_cnt;
  logic [WDW-1:0] timer;
  led_state_e     state;

  assign edge_det = sync1 & ~prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      prev       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync0      <= vsync;
      sync1      <= sync0;
      prev       <= sync1;
      frame_tick <= edge_det;
    end
  end

  // Counter holds between edges; it only advances on a detected frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      heartbeat <= 1'b0;
    end else if (edge_det) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // lost is registered alongside the timer so it rises the cycle timer saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= WD_MAX;
      lost  <= 1'b1;
    end else if (edge_det) begin
      timer <= '0;
      lost  <= 1'b0;
    end else if (timer != WD_MAX) begin
      timer <= timer + 1'b1;
      lost  <= (timer == WD_PRE);
    end
  end

  // led is registered from the next-state decision, so it follows state changes immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LED_OFF;
      led   <= 1'b0;
    end else if (!ready) begin
      state <= LED_OFF;
      led   <= 1'b0;
    end else begin
      case (state)
        LED_OFF: begin
          state <= LED_SEARCH;
          led   <= blink;
        end
        LED_SEARCH: begin
          if (!lost) begin
            state <= LED_LOCKED;
            led   <= heartbeat;
          end else begin
            led   <= blink;
          end
        end
        LED_LOCKED: begin
          if (lost) begin
            state <= LED_SEARCH;
            led   <= blink;
          end else begin
            led   <= heartbeat;
          end
        end
        default: begin
          state <= LED_OFF;
          led   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_MON_FPS_EN
  logic [FPS_W-1:0] edge_cnt;

  // An edge landing on the last window cycle is included in the published count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      fps      <= '0;
    end else if (win_last) begin
      fps      <= edge_det ? sat_inc(edge_cnt) : edge_cnt;
      edge_cnt <= '0;
    end else if (edge_det) begin
      edge_cnt <= sat_inc(edge_cnt);
    end
  end
`endif

endmodule

// File: rtl/dvp_frame_monitor.sv
// Multi-channel vsync health monitor driving status LEDs; shared prescaler lives here.
// Define FRAME_MON_FPS_EN to build the FPS measurement window; otherwise fps/fps_valid are 0.
module dvp_frame_monitor
  import frame_mon_pkg::*;
#(
  parameter int N_CH              = 2,
  parameter int FRAMES_PER_TOGGLE = 60,
  parameter int LOST_TIMEOUT      = 2000000,
  parameter int BLINK_DIV         = 22,
  parameter int WINDOW_CYCLES     = 27000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready,
  input  logic [N_CH-1:0]       vsync,
  output logic [N_CH-1:0]       frame_tick,
  output logic [N_CH-1:0]       heartbeat,
  output logic [N_CH-1:0]       lost,
  output logic [N_CH-1:0]       led,
  output logic [N_CH*FPS_W-1:0] fps,
  output logic                  fps_valid
);

  logic [BLINK_DIV:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + 1'b1;
  end

`ifdef FRAME_MON_FPS_EN
  localparam int WCW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(WINDOW_CYCLES - 1);

  logic [WCW-1:0] wcnt;
  logic           win_last;

  assign win_last = (wcnt == W_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt      <= '0;
      fps_valid <= 1'b0;
    end else begin
      wcnt      <= win_last ? '0 : wcnt + 1'b1;
      fps_valid <= win_last;
    end
  end
`else
  assign fps       = '0;
  assign fps_valid = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    frame_mon_chan #(
      .FRAMES_PER_TOGGLE (FRAMES_PER_TOGGLE),
      .LOST_TIMEOUT      (LOST_TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready      (ready),
      .vsync      (vsync[i]),
      .blink      (presc[BLINK_DIV]),
`ifdef FRAME_MON_FPS_EN
      .win_last   (win_last),
      .fps        (fps[i*FPS_W +: FPS_W]),
`endif
      .frame_tick (frame_tick[i]),
      .heartbeat  (heartbeat[i]),
      .lost       (lost[i]),
      .led        (led[i])
    );
  end

endmodule
